// File: rtl/stream_demux_pkg.sv
// Shared encodings and helpers for the stream_demux block.
package stream_demux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output holding register for a single demux channel.
// The slot is free when it is empty or is being drained this cycle.
module stream_demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  assign free  = !vld_p1 || ready;
  assign valid = vld_p1;
  assign data  = data_p1;

  // Stage p1: load wins over drain so a simultaneous drain and write keeps the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= wdata;
    end else if (ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer with addressed / round-robin routing.
// Optional broadcast input is enabled by defining STREAM_DEMUX_BCAST_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int ERR_W   = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [SEL_W-1:0]  rr_ptr_p1;
  logic [ERR_W-1:0]  err_cnt_p1;
  logic [SEL_W-1:0]  target;
  logic              in_range;
  logic              bcast;
  logic              ready_c;
  logic              accept;
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign target   = (mode == MODE_RR) ? rr_ptr_p1 : in_sel;
  assign in_range = int'(target) < NUM_CH;

  // Out-of-range selects are swallowed, so they never back-pressure the producer.
  always_comb begin
    ready_c = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(target) == k) ready_c = free[k];
    end
    if (bcast) ready_c = &free;
    accept = in_valid && ready_c;
    load   = '0;
    if (accept) begin
      if (bcast) begin
        load = '1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (int'(target) == k) load[k] = 1'b1;
        end
      end
    end
  end

  assign in_ready = ready_c;
  assign err_cnt  = err_cnt_p1;

  // Stage p1: round-robin pointer and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_p1  <= '0;
      err_cnt_p1 <= '0;
    end else if (accept && !bcast) begin
      if (mode == MODE_RR) begin
        rr_ptr_p1 <= (int'(rr_ptr_p1) == NUM_CH - 1) ? '0 : rr_ptr_p1 + 1'b1;
      end
      if (!in_range) begin
        err_cnt_p1 <= ERR_W'(sat_inc(32'(err_cnt_p1), 32'(ERR_MAX)));
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .wdata (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .data  (out_data[k*DATA_W +: DATA_W]),
      .free  (free[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for routing/flow control
// and a 3-channel instance for out-of-range drop counting.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode, in_valid, in_ready, bcast;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;

  logic        mode3, valid3, ready3, bcast3;
  logic [7:0]  data3;
  logic [1:0]  sel3;
  logic [2:0]  ov3, ord3;
  logic [23:0] od3;
  logic [7:0]  err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux #(.NUM_CH(4), .DATA_W(8), .ERR_W(8)) u4 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(bcast),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_cnt(err_cnt)
  );

  stream_demux #(.NUM_CH(3), .DATA_W(8), .ERR_W(8)) u3 (
    .clk(clk), .rst(rst), .mode(mode3), .in_valid(valid3), .in_ready(ready3),
    .in_data(data3), .in_sel(sel3),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(bcast3),
`endif
    .out_valid(ov3), .out_ready(ord3), .out_data(od3), .err_cnt(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer must hold data/select steady while stalled.
  logic       prev_stall;
  logic [7:0] prev_data;
  logic [1:0] prev_sel;
  always @(posedge clk) begin
    if (prev_stall === 1'b1 && rst === 1'b0) begin
      checks++;
      assert (in_data === prev_data && in_sel === prev_sel) else begin
        errors++;
        $error("FAIL stable_in observed=%0h/%0h expected=%0h/%0h", in_data, in_sel, prev_data, prev_sel);
      end
    end
    prev_stall <= in_valid && !in_ready;
    prev_data  <= in_data;
    prev_sel   <= in_sel;
  end

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0;
    out_ready = 4'b1111; bcast = 1'b0;
    mode3 = 1'b0; valid3 = 1'b0; data3 = 8'h00; sel3 = 2'd0; ord3 = 3'b111; bcast3 = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_err3", 32'(err3), 32'h0);
    chk("rst_ov3", 32'(ov3), 32'h0);
    rst = 1'b0;

    // Addressed routing
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2; #1;
    chk("addr_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    chk("addr_ov", 32'(out_valid), 32'h4);
    chk("addr_od2", 32'(out_data[23:16]), 32'hA5);
    tick();
    chk("addr_clear", 32'(out_valid), 32'h0);
    chk("addr_hold_data", 32'(out_data[23:16]), 32'hA5);

    // Back-pressure on channel 1
    out_ready = 4'b1101; in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd1; #1;
    chk("bp_ready0", 32'(in_ready), 32'h1);
    tick(); in_data = 8'h22; #1;
    chk("bp_stall_ready", 32'(in_ready), 32'h0);
    chk("bp_ov_first", 32'(out_valid), 32'h2);
    chk("bp_od1_first", 32'(out_data[15:8]), 32'h11);
    tick();
    chk("bp_stall_ready2", 32'(in_ready), 32'h0);
    chk("bp_od1_hold", 32'(out_data[15:8]), 32'h11);
    out_ready = 4'b1111; #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    chk("bp_ov_second", 32'(out_valid), 32'h2);
    chk("bp_od1_second", 32'(out_data[15:8]), 32'h22);
    tick();
    chk("bp_no_dup", 32'(out_valid), 32'h0);

    // Round-robin, six beats
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i); #1;
      chk("rr_ready", 32'(in_ready), 32'h1);
      tick();
      chk("rr_ov", 32'(out_valid), 32'(1 << (i % 4)));
      chk("rr_od", 32'(out_data[(i % 4)*8 +: 8]), 32'(i));
    end
    // Pointer now at 2; hold channel 2 not ready and walk around to it again
    out_ready = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      in_data = 8'(8'h10 + j); #1;
      tick();
      chk("rr2_ov", 32'(out_valid[(2 + j) % 4]), 32'h1);
      chk("rr2_od", 32'(out_data[((2 + j) % 4)*8 +: 8]), 32'(8'h10 + j));
    end
    in_data = 8'h14; #1;
    chk("rr_stall_ready", 32'(in_ready), 32'h0);
    tick();
    chk("rr_stall_ready2", 32'(in_ready), 32'h0);
    chk("rr_stall_od2", 32'(out_data[23:16]), 32'h10);
    chk("rr_stall_ov", 32'(out_valid), 32'h4);
    out_ready = 4'b1111; #1;
    chk("rr_unstall_ready", 32'(in_ready), 32'h1);
    tick();
    chk("rr_unstall_ov", 32'(out_valid), 32'h4);
    chk("rr_unstall_od2", 32'(out_data[23:16]), 32'h14);
    in_data = 8'h15; tick();
    chk("rr_wrap_ov", 32'(out_valid), 32'h8);
    chk("rr_wrap_od3", 32'(out_data[31:24]), 32'h15);
    mode = 1'b0; in_sel = 2'd1; in_data = 8'h20; tick();
    chk("mode_addr_ov", 32'(out_valid), 32'h2);
    chk("mode_addr_od1", 32'(out_data[15:8]), 32'h20);
    mode = 1'b1; in_data = 8'h21; tick();
    chk("mode_rr_ov", 32'(out_valid), 32'h1);
    chk("mode_rr_od0", 32'(out_data[7:0]), 32'h21);
    in_valid = 1'b0; tick();

    // Full throughput on channel 0
    mode = 1'b0; in_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i); #1;
      chk("tp_ready", 32'(in_ready), 32'h1);
      tick();
      chk("tp_ov0", 32'(out_valid[0]), 32'h1);
      chk("tp_od0", 32'(out_data[7:0]), 32'(8'h30 + i));
    end
    in_valid = 1'b0; tick();
    chk("tp_drain", 32'(out_valid), 32'h0);

    // Out-of-range drops on the 3-channel instance
    valid3 = 1'b1; sel3 = 2'd3; data3 = 8'hEE; #1;
    chk("err_ready", 32'(ready3), 32'h1);
    tick();
    chk("err_first", 32'(err3), 32'h1);
    chk("err_no_ov", 32'(ov3), 32'h0);
    repeat (253) tick();
    chk("err_254", 32'(err3), 32'd254);
    tick();
    chk("err_255", 32'(err3), 32'd255);
    repeat (45) tick();
    chk("err_sat", 32'(err3), 32'd255);
    chk("err_sat_no_ov", 32'(ov3), 32'h0);
    sel3 = 2'd2; data3 = 8'h42; tick();
    chk("ch3_addr_ov", 32'(ov3), 32'h4);
    chk("ch3_addr_od", 32'(od3[23:16]), 32'h42);
    chk("ch3_err_hold", 32'(err3), 32'd255);
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data3 = 8'(8'h50 + i); tick();
      chk("ch3_rr_ov", 32'(ov3), 32'(1 << (i % 3)));
      chk("ch3_rr_od", 32'(od3[(i % 3)*8 +: 8]), 32'(8'h50 + i));
    end
    valid3 = 1'b0;

    // Reset mid-operation with channel 3 held full
    out_ready = 4'b0111; mode = 1'b0; in_sel = 2'd3; in_data = 8'h77; in_valid = 1'b1;
    tick();
    chk("mid_ov3", 32'(out_valid), 32'h8);
    mode = 1'b1; in_data = 8'h78; tick();
    chk("mid_rr_ov", 32'(out_valid), 32'hA);
    chk("mid_rr_od1", 32'(out_data[15:8]), 32'h78);
    in_valid = 1'b0; tick();
    chk("mid_hold_ov", 32'(out_valid), 32'h8);
`ifdef STREAM_DEMUX_BCAST_EN
    bcast = 1'b1; in_data = 8'h5A; in_valid = 1'b1; #1;
    chk("bc_stall_ready", 32'(in_ready), 32'h0);
    tick();
    chk("bc_stall_ov", 32'(out_valid), 32'h8);
    chk("bc_stall_od3", 32'(out_data[31:24]), 32'h77);
`endif
    rst = 1'b1; tick();
    chk("mid_rst_ov", 32'(out_valid), 32'h0);
    chk("mid_rst_od", out_data, 32'h0);
    rst = 1'b0;
`ifdef STREAM_DEMUX_BCAST_EN
    #1;
    chk("bc_retry_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bc_ov", 32'(out_valid), 32'hF);
    chk("bc_od", out_data, 32'h5A5A5A5A);
    bcast = 1'b0;
`endif
    in_valid = 1'b1; in_data = 8'h79; tick();
    chk("mid_ptr0_ov0", 32'(out_valid[0]), 32'h1);
    chk("mid_ptr0_od0", 32'(out_data[7:0]), 32'h79);
    in_valid = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
